// File: rtl/dmem_access_ctrl.sv
// Initiator-side data-memory controller: one load/store in flight, registered memory strobes.
// Optional out-of-range rejection is compiled in with `define DMEM_BOUNDS_CHECK_EN.
module dmem_access_ctrl #(
    parameter int DATA_W      = 32,
    parameter int MEM_SIZE    = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall,
    output logic [DATA_W-1:0] mem_address,
    output logic              mem_write,
    output logic              mem_read,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [1:0]        dbg_state
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || MEM_SIZE < 1) begin : g_param_check
        $error("dmem_access_ctrl: WAIT_CYCLES must be 0..15 and MEM_SIZE positive");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE and the requester holds req_valid until then.
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic              resp_valid_q, resp_valid_d;
    logic              oob;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob = (req_addr >= DATA_W'(MEM_SIZE));
`else
    assign oob = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wr_d    = req_write;
                    wdata_d = req_wdata;
                    err_d   = oob;
                    if (oob) begin
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (wr_q) begin
                    state_d = ST_RESP;
                end else if (WAIT_CYCLES == 0) begin
                    rdata_d = mem_read_data;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d = mem_read_data;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are computed from the next state so they leave a flop and stay clean for whole periods.
    always_comb begin
        mem_write_d  = (state_d == ST_ISSUE) && wr_d;
        mem_read_d   = ((state_d == ST_ISSUE) || (state_d == ST_WAIT)) && !wr_d;
        resp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            wr_q         <= wr_d;
            err_q        <= err_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign stall          = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = rdata_q;
    assign resp_err       = err_q;
    assign mem_address    = addr_q;
    assign mem_write      = mem_write_q;
    assign mem_read       = mem_read_q;
    assign mem_write_data = wdata_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, reset-in-flight sequence, random loads/stores vs a model.
module tb_dmem_access_ctrl;
  localparam int DW    = 32;
  localparam int MSZ   = 32;
  localparam int WC    = 1;
  localparam int RAM_N = 64;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [DW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, resp_valid, resp_err, stall, mem_write, mem_read;
  logic [DW-1:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
  logic [1:0]    dbg_state;

  dmem_access_ctrl #(.DATA_W(DW), .MEM_SIZE(MSZ), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall), .mem_address(mem_address), .mem_write(mem_write), .mem_read(mem_read),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hC0DE0000 + 32'(i) * 32'h101;
  endfunction

  // memory: combinational read, write on rising edge while mem_write
  logic [DW-1:0] ram [0:RAM_N-1];
  assign mem_read_data = ram[mem_address[5:0]];
  initial begin
    for (int i = 0; i < RAM_N; i++) ram[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_write) ram[mem_address[5:0]] = mem_write_data;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req_ready"}, req_ready, 1);
    chk({tag, ".resp_valid"}, resp_valid, 0);
    chk({tag, ".resp_rdata"}, resp_rdata, 0);
    chk({tag, ".resp_err"}, resp_err, 0);
    chk({tag, ".stall"}, stall, 0);
    chk({tag, ".mem_write"}, mem_write, 0);
    chk({tag, ".mem_read"}, mem_read, 0);
    chk({tag, ".mem_address"}, mem_address, 0);
    chk({tag, ".mem_write_data"}, mem_write_data, 0);
    chk({tag, ".state"}, dbg_state, 0);
  endtask

  // reference model: memory contents and last returned data, per transaction
  logic [DW-1:0] ref_mem [0:RAM_N-1];
  logic [DW-1:0] last_rd = '0;

  function automatic void model(input logic w, input logic [DW-1:0] a, input logic [DW-1:0] d,
                                output int e_lat, output logic [DW-1:0] e_rd, output logic e_er,
                                output int e_nwr, output int e_nrd);
    logic oob;
    oob = BOUNDS && (a >= MSZ);
    if (oob) begin
      e_lat = 1; e_rd = '0; e_er = 1'b1; e_nwr = 0; e_nrd = 0;
    end else if (w) begin
      e_lat = 2; e_rd = last_rd; e_er = 1'b0; e_nwr = 1; e_nrd = 0;
      ref_mem[a[5:0]] = d;
    end else begin
      e_lat = 2 + WC; e_rd = ref_mem[a[5:0]]; e_er = 1'b0; e_nwr = 0; e_nrd = 1 + WC;
    end
    last_rd = e_rd;
  endfunction

  // observed per-transaction results
  int            o_lat, o_nwr, o_nrd, o_nst, o_wait;
  logic [DW-1:0] o_rd;
  logic          o_er, o_bad, o_ovl;

  // driver: call at a falling edge; returns at the falling edge where resp_valid is seen
  task automatic do_txn(input logic w, input logic [DW-1:0] a, input logic [DW-1:0] d, input logic hold);
    o_lat = 0; o_nwr = 0; o_nrd = 0; o_nst = 0; o_wait = 0; o_rd = '0; o_er = 1'b0;
    o_bad = 1'b0; o_ovl = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && o_wait < 20) begin
      @(negedge clk);
      o_wait++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (mem_write) o_nwr++;
      if (mem_read) o_nrd++;
      if (stall) o_nst++;
      if (mem_write && mem_read) o_ovl = 1'b1;
      if ((mem_write || mem_read) && mem_address !== a) o_bad = 1'b1;
      if (mem_write && mem_write_data !== d) o_bad = 1'b1;
      if (resp_valid && (mem_write || mem_read || stall)) o_bad = 1'b1;
      if (resp_valid) begin
        o_lat = c; o_rd = resp_rdata; o_er = resp_err;
        break;
      end
      @(negedge clk);
    end
    if (o_lat == 0) chk("resp_timeout", 0, 1);
  endtask

  task automatic check_txn(input string tag, input int e_lat, input logic [DW-1:0] e_rd, input logic e_er,
                           input int e_nwr, input int e_nrd, input int e_wait);
    chk({tag, ".latency"}, o_lat, e_lat);
    chk({tag, ".rdata"}, o_rd, e_rd);
    chk({tag, ".err"}, o_er, e_er);
    chk({tag, ".write_cycles"}, o_nwr, e_nwr);
    chk({tag, ".read_cycles"}, o_nrd, e_nrd);
    chk({tag, ".stall_cycles"}, o_nst, e_lat - 1);
    chk({tag, ".accept_wait"}, o_wait, e_wait);
    chk({tag, ".addr_data_ok"}, o_bad, 0);
    chk({tag, ".no_overlap"}, o_ovl, 0);
  endtask

  typedef struct {
    logic          w;
    logic [DW-1:0] a;
    logic [DW-1:0] d;
    logic          hold;
    int            e_lat;
    logic [DW-1:0] e_rd;
    logic          e_er;
    int            e_nwr;
    int            e_nrd;
    int            e_wait;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int            m_lat, m_nwr, m_nrd, resp_seen;
    logic [DW-1:0] m_rd;
    logic          m_er;

    vecs[0] = '{1'b1, 32'd5,  32'hDEADBEEF, 1'b0, 2,      32'h0,        1'b0, 1, 0,      0};
    vecs[1] = '{1'b0, 32'd5,  32'h0,        1'b0, 2 + WC, 32'hDEADBEEF, 1'b0, 0, 1 + WC, 1};
    vecs[2] = '{1'b1, 32'd0,  32'h1,        1'b1, 2,      32'hDEADBEEF, 1'b0, 1, 0,      1};
    vecs[3] = '{1'b0, 32'd0,  32'h0,        1'b0, 2 + WC, 32'h1,        1'b0, 0, 1 + WC, 1};
    vecs[4] = '{1'b1, 32'd31, 32'h12345678, 1'b0, 2,      32'h1,        1'b0, 1, 0,      1};
    vecs[5] = '{1'b0, 32'd31, 32'h0,        1'b0, 2 + WC, 32'h12345678, 1'b0, 0, 1 + WC, 1};
    if (BOUNDS)
      vecs[6] = '{1'b0, 32'd40, 32'h0, 1'b0, 1, 32'h0, 1'b1, 0, 0, 1};
    else
      vecs[6] = '{1'b0, 32'd40, 32'h0, 1'b0, 2 + WC, init_word(40), 1'b0, 0, 1 + WC, 1};
    vecs[7] = '{1'b0, 32'd31, 32'h0,        1'b0, 2 + WC, 32'h12345678, 1'b0, 0, 1 + WC, 1};

    for (int i = 0; i < RAM_N; i++) ref_mem[i] = init_word(i);

    // reset
    #2 rst = 1'b1;
    #1 chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("after_release");

    // directed table
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].hold);
      check_txn($sformatf("vec%0d", i), vecs[i].e_lat, vecs[i].e_rd, vecs[i].e_er,
                vecs[i].e_nwr, vecs[i].e_nrd, vecs[i].e_wait);
      model(vecs[i].w, vecs[i].a, vecs[i].d, m_lat, m_rd, m_er, m_nwr, m_nrd);
    end

    // reset while a load sits in WAIT
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid.in_wait", dbg_state, 2);
    chk("rst_mid.read_before", mem_read, 1);
    rst = 1'b1;
    #1 chk_reset_vals("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    resp_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    chk("rst_mid.no_resp", resp_seen, 0);
    last_rd = '0;
    do_txn(1'b0, 32'd5, 32'h0, 1'b0);
    model(1'b0, 32'd5, 32'h0, m_lat, m_rd, m_er, m_nwr, m_nrd);
    check_txn("after_rst_load", m_lat, m_rd, m_er, m_nwr, m_nrd, 0);

    // random traffic against the model
    for (int n = 0; n < 40; n++) begin
      logic          w;
      logic [DW-1:0] a, d;
      w = 1'($urandom_range(0, 1));
      a = DW'($urandom_range(0, RAM_N - 1));
      d = $urandom;
      do_txn(w, a, d, 1'b0);
      model(w, a, d, m_lat, m_rd, m_er, m_nwr, m_nrd);
      check_txn($sformatf("rnd%0d", n), m_lat, m_rd, m_er, m_nwr, m_nrd, 1);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator-side controller for the word-addressed data memory.
- Accepts one load/store request at a time from the pipeline MEM stage over a valid/ready handshake.
- Sequences the memory's address, mem_write, mem_read and write_data signals, waits a fixed read latency, and captures read data.
- Returns a one-cycle response pulse, holding off the pipeline (stall) while a request is in flight.

Parameters:
- DATA_W, 32, width of data and address buses.
- MEM_SIZE, 32, number of valid memory words; used by the bounds check.
- WAIT_CYCLES, 1, cycles mem_read is held after issue before read data is sampled; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline presents a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  DATA_W  word address.
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  controller can accept a request (IDLE only).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  load data; valid while resp_valid=1.
- resp_err  out  1  out-of-range access; only meaningful with the optional feature.
- stall  out  1  high while a request is in flight (ISSUE or WAIT).
- mem_address  out  DATA_W  to memory address.
- mem_write  out  1  to memory write strobe.
- mem_read  out  1  to memory read strobe.
- mem_write_data  out  DATA_W  to memory write data.
- mem_read_data  in  DATA_W  from memory read data (combinational read).

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Implement as a registered state machine; all outputs registered or decoded from registered state.
- Reset values (asynchronous rst): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, stall=0, mem_write=0, mem_read=0, mem_address=0, mem_write_data=0, wait counter=0.
- IDLE:
  - req_ready=1.
  - On req_valid at a clock edge: latch addr, write flag and wdata; go to ISSUE.
  - No other inputs are sampled.
- ISSUE (exactly 1 cycle):
  - mem_address = latched addr.
  - Store: mem_write=1, mem_write_data = latched wdata, mem_read=0.
  - Load: mem_read=1, mem_write=0.
  - Next state:
    - Store: go to RESP.
    - Load with WAIT_CYCLES=0: capture mem_read_data at the end of this cycle, then go to RESP.
    - Load otherwise: load counter with WAIT_CYCLES, go to WAIT.
- WAIT (load only):
  - mem_read=1 and mem_address held; counter decrements each cycle.
  - When counter reaches 1: capture mem_read_data into resp_rdata, go to RESP.
- RESP (1 cycle):
  - resp_valid=1, all mem strobes 0, stall=0; go to IDLE.
  - Stores leave resp_rdata at its previous value.
  - A new request can be accepted in the cycle after RESP.
- Latency, counting the request-accept edge as cycle 0:
  - Store: resp_valid in cycle 2.
  - Load: resp_valid in cycle 2+WAIT_CYCLES.
- mem_write is asserted for exactly one full clock period per store. The memory samples on both clock edges, so no glitch or partial cycle is permitted.
- stall = (state==ISSUE || state==WAIT).
- req_valid while not IDLE is ignored; the requester must hold it until req_ready.
- rst asserted mid-transaction: strobes drop immediately and the transaction is discarded with no resp_valid. A store whose mem_write was already high may or may not have been written.
- Address is passed through unmodified; no width truncation.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined:
  - A request with addr >= MEM_SIZE skips ISSUE/WAIT; no mem strobe is asserted.
  - Goes IDLE -> RESP with resp_err=1 and resp_rdata=0.
  - resp_err is cleared on the next accepted in-range request.
- Undefined: no check is performed, resp_err is tied to 0, and every address is issued to memory.

Test Plan:
1. Reset mid-test then release: all outputs at reset values, req_ready=1, state IDLE.
2. Store addr=5, wdata=0xDEADBEEF: mem_write=1 for exactly one cycle with mem_address=5; resp_valid in cycle 2; resp_err=0.
3. Load addr=5 after test 2, WAIT_CYCLES=1: mem_read high cycles 1-2, resp_valid in cycle 3 with resp_rdata=0xDEADBEEF; stall high cycles 1-2.
4. Back-to-back: store addr=0 (0x1) with req_valid held, then load addr=0: second accept occurs the cycle after RESP; load returns 0x1; no overlap of mem_write and mem_read.
5. rst pulsed while in WAIT of a load: mem_read drops asynchronously, no resp_valid, next load addr=5 completes normally.
6. With DMEM_BOUNDS_CHECK_EN, load addr=40 (MEM_SIZE=32): resp_valid in cycle 1 with resp_err=1, resp_rdata=0, mem_read never asserted. Without the macro, the same request issues mem_read with mem_address=40 and resp_err=0.
